// File: rtl/riscv_pkg.sv
// riscv_pkg: FUNCT3 load/store codes and the memory-stage FSM encoding.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores, lane shift and extension for loads.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    // Store steering: replicate the datum so whichever lane is enabled carries it.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load path: halfwords only honour addr[1], words ignore the low bits.
    always_comb begin
        lane = 2'b00;
        case (funct3)
            F3_B, F3_BU: lane = addr_lo;
            F3_H, F3_HU: lane = {addr_lo[1], 1'b0};
            default:     lane = 2'b00;
        endcase
        shifted   = rdata >> {lane, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage with branch resolve, req/ack data-memory FSM and MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of
// silently dropping the offending low address bits.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        zero_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [2:0]  FUNCT3_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] PC_Branch_in,
    input  logic [31:0] ALUout_in,
    input  logic [31:0] REG_DATA2_MUX_in,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] PC_Branch_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [4:0]  rd_out,
    output logic [31:0] read_data_out,
    output logic [31:0] ALUout_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_op, misalign, cnt_at_limit;
    logic             issue, trap, abort;
    logic [3:0]       lsa_be;
    logic [31:0]      lsa_wdata, lsa_load_data;

    assign PCSrc         = Branch_in & zero_in;
    assign PC_Branch_out = PC_Branch_in;
    assign mem_op        = MemRead_in | MemWrite_in;
    assign cnt_at_limit  = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (((FUNCT3_in == F3_H) || (FUNCT3_in == F3_HU)) && ALUout_in[0])
                   || ((FUNCT3_in == F3_W) && (ALUout_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    load_store_align u_align (
        .funct3     (FUNCT3_in),
        .addr_lo    (ALUout_in[1:0]),
        .store_data (REG_DATA2_MUX_in),
        .rdata      (dmem_rdata),
        .be         (lsa_be),
        .wdata      (lsa_wdata),
        .load_data  (lsa_load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, stall and access strobes.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        issue   = 1'b0;
        trap    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misalign) begin
                        trap = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        stall   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                end else if (cnt_at_limit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase
    end

    // Memory port latch, timeout counter, event pulses and MEM/WB register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wdata    <= 32'h0;
            dmem_be       <= 4'h0;
            bus_err_out   <= 1'b0;
            misalign_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            rd_out        <= 5'h0;
            read_data_out <= 32'h0;
            ALUout_out    <= 32'h0;
        end else begin
            if (issue) begin
                cnt_q      <= '0;
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_in;
                dmem_addr  <= {ALUout_in[31:2], 2'b00};
                dmem_wdata <= lsa_wdata;
                dmem_be    <= lsa_be;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (dmem_ack || abort) dmem_req <= 1'b0;
            end
            bus_err_out  <= abort;
            misalign_out <= trap;
            if (!stall) begin
                RegWrite_out  <= RegWrite_in & ~abort & ~trap;
                MemtoReg_out  <= MemtoReg_in;
                rd_out        <= rd_in;
                read_data_out <= lsa_load_data;
                ALUout_out    <= ALUout_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors; a scoreboard queue holds expected MEM/WB captures.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk, reset;
    logic        zero_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in;
    logic [2:0]  FUNCT3_in;
    logic [4:0]  rd_in;
    logic [31:0] PC_Branch_in, ALUout_in, REG_DATA2_MUX_in;
    logic        stall, PCSrc;
    logic [31:0] PC_Branch_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        RegWrite_out, MemtoReg_out;
    logic [4:0]  rd_out;
    logic [31:0] read_data_out, ALUout_out;
    logic        bus_err_out, misalign_out;

    typedef struct packed {
        logic        br, zero, rw, m2r, mr, mw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pcb, alu, sd;
    } ins_t;

    typedef struct packed {
        logic        rw, m2r;
        logic [4:0]  rd;
        logic [31:0] alu, rdata;
        logic        chk_rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_cap = 1'b0;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .zero_in(zero_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
        .FUNCT3_in(FUNCT3_in), .rd_in(rd_in), .PC_Branch_in(PC_Branch_in),
        .ALUout_in(ALUout_in), .REG_DATA2_MUX_in(REG_DATA2_MUX_in),
        .stall(stall), .PCSrc(PCSrc), .PC_Branch_out(PC_Branch_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .rd_out(rd_out),
        .read_data_out(read_data_out), .ALUout_out(ALUout_out),
        .bus_err_out(bus_err_out), .misalign_out(misalign_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic br, input logic zero, input logic rw, input logic m2r,
                                input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        ins_t i;
        i.br = br; i.zero = zero; i.rw = rw; i.m2r = m2r; i.mr = mr; i.mw = mw;
        i.f3 = f3; i.rd = rd; i.alu = alu; i.sd = sd;
        i.pcb = 32'h8000_0000 | {27'h0, rd};
        return i;
    endfunction

    function automatic exp_t mkx(input logic rw, input logic m2r, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic chk, input logic [31:0] rdata);
        exp_t e;
        e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.chk_rdata = chk; e.rdata = rdata;
        return e;
    endfunction

    task automatic apply(input ins_t i);
        Branch_in = i.br; zero_in = i.zero; RegWrite_in = i.rw; MemtoReg_in = i.m2r;
        MemRead_in = i.mr; MemWrite_in = i.mw; FUNCT3_in = i.f3; rd_in = i.rd;
        PC_Branch_in = i.pcb; ALUout_in = i.alu; REG_DATA2_MUX_in = i.sd;
    endtask

    // Apply one instruction, act as memory, and stop right after its MEM/WB capture edge.
    task automatic run(input string name, input ins_t i, input exp_t e,
                       input logic [31:0] ex_addr, input logic ex_we, input logic [3:0] ex_be,
                       input logic [31:0] ex_wdata, input int ack_cycle, input logic [31:0] rdata,
                       input int ex_waits, input int ex_stalls);
        int wcyc, stalls, bad;
        bit done;
        wcyc = 0; stalls = 0; bad = 0; done = 1'b0;
        apply(i);
        sb.push_back(e);
        #1;
        check({name, ".pcsrc"}, 32'(PCSrc), 32'(i.br & i.zero));
        check({name, ".pcb"}, PC_Branch_out, i.pcb);
        for (int it = 0; it < 64 && !done; it++) begin
            if (dmem_req) begin
                wcyc++;
                if (dmem_addr !== ex_addr || dmem_we !== ex_we) bad++;
                if (ex_we && (dmem_be !== ex_be || dmem_wdata !== ex_wdata)) bad++;
                if (wcyc == ack_cycle) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        check({name, ".completed"}, 32'(done), 32'd1);
        check({name, ".req_cycles"}, 32'(wcyc), 32'(ex_waits));
        check({name, ".stall_cycles"}, 32'(stalls), 32'(ex_stalls));
        check({name, ".req_fields"}, 32'(bad), 32'd0);
    endtask

    // Monitor: every edge taken with stall low must match the oldest expected capture.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_cap = 1'b0;
            end else begin
                if (prev_cap) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL memwb_extra: capture of rd %0d, expected no capture", rd_out);
                    end else begin
                        mon_e = sb.pop_front();
                        check("memwb.regwrite", 32'(RegWrite_out), 32'(mon_e.rw));
                        check("memwb.memtoreg", 32'(MemtoReg_out), 32'(mon_e.m2r));
                        check("memwb.rd", 32'(rd_out), 32'(mon_e.rd));
                        check("memwb.aluout", ALUout_out, mon_e.alu);
                        if (mon_e.chk_rdata) check("memwb.read_data", read_data_out, mon_e.rdata);
                    end
                end
                prev_cap = !stall;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        apply(mk(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0));
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.dmem_req", 32'(dmem_req), 32'd0);
        check("rst.dmem_we", 32'(dmem_we), 32'd0);
        check("rst.dmem_addr", dmem_addr, 32'h0);
        check("rst.dmem_wdata", dmem_wdata, 32'h0);
        check("rst.dmem_be", 32'(dmem_be), 32'h0);
        check("rst.regwrite", 32'(RegWrite_out), 32'd0);
        check("rst.read_data", read_data_out, 32'h0);
        check("rst.aluout", ALUout_out, 32'h0);
        check("rst.bus_err", 32'(bus_err_out), 32'd0);
        check("rst.misalign", 32'(misalign_out), 32'd0);
        reset = 1'b0;

        run("alu_br_taken", mk(1, 1, 1, 0, 0, 0, 3'b000, 5'd5, 32'h1234_5678, 32'h0),
            mkx(1, 0, 5'd5, 32'h1234_5678, 0, 32'h0), 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
        run("alu_br_not", mk(1, 0, 1, 0, 0, 0, 3'b000, 5'd6, 32'h0BAD_F00D, 32'h0),
            mkx(1, 0, 5'd6, 32'h0BAD_F00D, 0, 32'h0), 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
        run("lb", mk(0, 0, 1, 1, 1, 0, 3'b000, 5'd7, 32'h11, 32'h0),
            mkx(1, 1, 5'd7, 32'h11, 1, 32'hFFFF_FF80), 32'h10, 0, 4'h0, 32'h0, 1, 32'h0000_8000, 1, 1);
        run("sb", mk(0, 0, 0, 0, 0, 1, 3'b000, 5'd0, 32'h23, 32'h1234_56A5),
            mkx(0, 0, 5'd0, 32'h23, 0, 32'h0), 32'h20, 1, 4'b1000, 32'hA5A5_A5A5, 2, 32'h0, 2, 2);
        run("sh", mk(0, 0, 0, 0, 0, 1, 3'b001, 5'd0, 32'h42, 32'h7777_BEEF),
            mkx(0, 0, 5'd0, 32'h42, 0, 32'h0), 32'h40, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0, 1, 1);
        run("sw", mk(0, 0, 0, 0, 0, 1, 3'b010, 5'd0, 32'h100, 32'hDEAD_BEEF),
            mkx(0, 0, 5'd0, 32'h100, 0, 32'h0), 32'h100, 1, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0, 1, 1);
        run("lh_slow", mk(0, 0, 1, 1, 1, 0, 3'b001, 5'd8, 32'h102, 32'h0),
            mkx(1, 1, 5'd8, 32'h102, 1, 32'hFFFF_8001), 32'h100, 0, 4'h0, 32'h0, 6, 32'h8001_1234, 6, 6);
        run("lbu", mk(0, 0, 1, 1, 1, 0, 3'b100, 5'd9, 32'h103, 32'h0),
            mkx(1, 1, 5'd9, 32'h103, 1, 32'h0000_00F0), 32'h100, 0, 4'h0, 32'h0, 1, 32'hF000_0000, 1, 1);
        run("lhu", mk(0, 0, 1, 1, 1, 0, 3'b101, 5'd10, 32'h0, 32'h0),
            mkx(1, 1, 5'd10, 32'h0, 1, 32'h0000_9ABC), 32'h0, 0, 4'h0, 32'h0, 3, 32'h1234_9ABC, 3, 3);
        run("lw", mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd11, 32'h8, 32'h0),
            mkx(1, 1, 5'd11, 32'h8, 1, 32'hCAFE_F00D), 32'h8, 0, 4'h0, 32'h0, 1, 32'hCAFE_F00D, 1, 1);

        run("lw_timeout", mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd12, 32'h200, 32'h0),
            mkx(0, 1, 5'd12, 32'h200, 0, 32'h0), 32'h200, 0, 4'h0, 32'h0, 0, 32'h0, 16, 16);
        check("timeout.bus_err_pulse", 32'(bus_err_out), 32'd1);
        check("timeout.req_dropped", 32'(dmem_req), 32'd0);
        run("alu_after_to", mk(0, 0, 1, 0, 0, 0, 3'b000, 5'd13, 32'h1, 32'h0),
            mkx(1, 0, 5'd13, 32'h1, 0, 32'h0), 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
        check("timeout.bus_err_end", 32'(bus_err_out), 32'd0);

        // Reset in the middle of an outstanding load.
        apply(mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd20, 32'h30, 32'h0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst.req_before", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst.req", 32'(dmem_req), 32'd0);
        check("midrst.addr", dmem_addr, 32'h0);
        check("midrst.regwrite", 32'(RegWrite_out), 32'd0);
        apply(mk(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0));
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        run("lw_after_rst", mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd14, 32'h14, 32'h0),
            mkx(1, 1, 5'd14, 32'h14, 1, 32'h1122_3344), 32'h14, 0, 4'h0, 32'h0, 2, 32'h1122_3344, 2, 2);

`ifdef MEM_MISALIGN_TRAP_EN
        run("lw_mis", mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd15, 32'h6, 32'h0),
            mkx(0, 1, 5'd15, 32'h6, 0, 32'h0), 32'h0, 0, 4'h0, 32'h0, 0, 32'h5566_7788, 0, 0);
        check("lw_mis.misalign_pulse", 32'(misalign_out), 32'd1);
`else
        run("lw_mis", mk(0, 0, 1, 1, 1, 0, 3'b010, 5'd15, 32'h6, 32'h0),
            mkx(1, 1, 5'd15, 32'h6, 1, 32'h5566_7788), 32'h4, 0, 4'h0, 32'h0, 1, 32'h5566_7788, 1, 1);
        check("lw_mis.be", 32'(dmem_be), 32'hF);
        check("lw_mis.misalign_tied", 32'(misalign_out), 32'd0);
`endif
        run("alu_last", mk(0, 0, 1, 0, 0, 0, 3'b000, 5'd16, 32'h77, 32'h0),
            mkx(1, 0, 5'd16, 32'h77, 0, 32'h0), 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
        check("misalign_end", 32'(misalign_out), 32'd0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
